capture_buffer: RTL and testbench

- Sits directly downstream of the capture stage. It consumes the capture AXI-stream and stores samples in a circular on-chip memory of 2^saddr_w words.
- Keeps pre-trigger history and records where the trigger occurred.
- After capture completes, replays the stored samples oldest-first on an AXI-stream master for the DMA/host interface.

---
 rtl/capture_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_capture_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// Circular capture memory with pre-trigger history; oldest-first replay, first beat 2 cycles after read_start, stalls on m_tready.
// Optional trailer beat {trig_seen, trig_pos, count} when CAPTURE_BUFFER_TRAILER_EN is defined.
module capture_buffer #(
    parameter int size    = 32,
    parameter int saddr_w = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [size-1:0]    s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               triggered,
    input  logic               done,
    input  logic               arm,
    input  logic               read_start,
    input  logic               clear,
    output logic [size-1:0]    m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic [saddr_w:0]   count,
    output logic [saddr_w-1:0] trig_pos,
    output logic               trig_seen,
    output logic [1:0]         state
);

    localparam int DEPTH = 1 << saddr_w;

`ifdef CAPTURE_BUFFER_TRAILER_EN
    localparam logic TRL_EN = 1'b1;
`else
    localparam logic TRL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        HOLD    = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [size-1:0]    r_mem [DEPTH];
    logic [size-1:0]    r_rd_q;
    logic [saddr_w-1:0] r_wr_ptr, r_rd_ptr, r_trig_wr, r_trig_pos;
    logic [saddr_w:0]   r_count, r_left;
    logic               r_trig_seen;
    logic               r_rd_vld, r_rd_last, r_rd_trl;
    logic               r_skid_vld, r_skid_last;
    logic [size-1:0]    r_skid_dat;
    logic               r_out_vld, r_out_last;
    logic [size-1:0]    r_out_dat;

    logic               w_wr_en, w_trig_hit, w_arm_go, w_start, w_pop;
    logic               w_issue, w_issue_last, w_issue_trl;
    logic [saddr_w-1:0] w_wr_ptr_nxt, w_trig_wr_nxt, w_base_fill, w_trig_pos_fill;
    logic [saddr_w-1:0] w_rd_base, w_issue_addr;
    logic [saddr_w:0]   w_count_nxt, w_total, w_issue_left;
    logic [1:0]         w_occ;
    logic [size-1:0]    w_trl_word, w_push_dat;

    assign w_wr_en      = (r_state == FILL) && s_tvalid && !clear;
    assign w_wr_ptr_nxt = r_wr_ptr + saddr_w'(w_wr_en);
    assign w_count_nxt  = (w_wr_en && !r_count[saddr_w]) ? r_count + 1'b1 : r_count;
    assign w_trig_hit   = (r_state == FILL) && triggered && !r_trig_seen;
    assign w_trig_wr_nxt = w_trig_hit ? r_wr_ptr : r_trig_wr;
    // Trigger position must reflect a beat (or trigger) landing on the same cycle as done.
    assign w_base_fill     = w_count_nxt[saddr_w] ? w_wr_ptr_nxt : '0;
    assign w_trig_pos_fill = (r_trig_seen || w_trig_hit) ? (w_trig_wr_nxt - w_base_fill) : '0;
    assign w_rd_base       = r_count[saddr_w] ? r_wr_ptr : '0;

    assign w_arm_go = arm && !clear && ((r_state == IDLE) || (r_state == HOLD));
    assign w_total  = r_count + (saddr_w+1)'(TRL_EN);
    assign w_start  = (r_state == HOLD) && read_start && !arm && !clear && (w_total != '0);
    assign w_pop    = r_out_vld && m_tready;

    // Reads are only issued when the output register plus skid can absorb them.
    assign w_occ   = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_rd_vld) - 2'(w_pop);
    assign w_issue = w_start ||
                     ((r_state == READOUT) && !clear && (r_left != '0) && (w_occ < 2'd2));
    assign w_issue_left = w_start ? w_total   : r_left;
    assign w_issue_addr = w_start ? w_rd_base : r_rd_ptr;
    assign w_issue_last = (w_issue_left == (saddr_w+1)'(1));
    assign w_issue_trl  = TRL_EN && w_issue_last;

`ifdef CAPTURE_BUFFER_TRAILER_EN
    localparam int TRL_W = 2*saddr_w + 2;
    localparam int EXT_W = (size > TRL_W) ? size : TRL_W;
    logic [TRL_W-1:0] w_trl_raw;
    logic [EXT_W-1:0] w_trl_ext;
    assign w_trl_raw  = {r_trig_seen, r_trig_pos, r_count};
    assign w_trl_ext  = EXT_W'(w_trl_raw);
    assign w_trl_word = w_trl_ext[size-1:0];
`else
    assign w_trl_word = '0;
`endif

    assign w_push_dat = r_rd_trl ? w_trl_word : r_rd_q;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= s_tdata;
        if (w_issue) r_rd_q <= r_mem[w_issue_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (arm) w_state_nxt = FILL;
                FILL:    if (done) w_state_nxt = HOLD;
                HOLD:    if (arm) w_state_nxt = FILL;
                         else if (w_start) w_state_nxt = READOUT;
                READOUT: if (w_pop && r_out_last) w_state_nxt = HOLD;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trig_wr   <= '0;
            r_trig_pos  <= '0;
            r_trig_seen <= 1'b0;
        end else if (w_arm_go) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trig_pos  <= '0;
            r_trig_seen <= 1'b0;
        end else if ((r_state == FILL) && !clear) begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_trig_hit) begin
                r_trig_wr   <= r_wr_ptr;
                r_trig_seen <= 1'b1;
            end
            if (done) r_trig_pos <= w_trig_pos_fill;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr  <= '0;
            r_left    <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_trl  <= 1'b0;
        end else if (clear) begin
            r_left   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_ptr  <= w_issue_addr + 1'b1;
                r_left    <= w_issue_left - 1'b1;
                r_rd_last <= w_issue_last;
                r_rd_trl  <= w_issue_trl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_dat   <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_dat  <= '0;
        end else if (!r_out_vld || w_pop) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= r_skid_dat;
                r_out_last <= r_skid_last;
                r_skid_vld <= r_rd_vld;
                if (r_rd_vld) begin
                    r_skid_dat  <= w_push_dat;
                    r_skid_last <= r_rd_last;
                end
            end else if (r_rd_vld) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= w_push_dat;
                r_out_last <= r_rd_last;
            end else begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end else if (r_rd_vld) begin
            r_skid_vld  <= 1'b1;
            r_skid_dat  <= w_push_dat;
            r_skid_last <= r_rd_last;
        end
    end

    assign s_tready  = (r_state != READOUT);
    assign m_tdata   = r_out_dat;
    assign m_tvalid  = r_out_vld;
    assign m_tlast   = r_out_last;
    assign count     = r_count;
    assign trig_pos  = r_trig_pos;
    assign trig_seen = r_trig_seen;
    assign state     = r_state;

endmodule

// File: tb/tb_capture_buffer.sv
// Randomized bench for capture_buffer (saddr_w=4) against a queue-based sample history model.
module tb_capture_buffer;

    localparam int SZ    = 32;
    localparam int SA    = 4;
    localparam int DEPTH = 1 << SA;
`ifdef CAPTURE_BUFFER_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, s_tvalid, s_tready, triggered, done, arm, read_start, clear;
    logic [SZ-1:0] s_tdata, m_tdata;
    logic          m_tvalid, m_tready, m_tlast, trig_seen;
    logic [SA:0]   count;
    logic [SA-1:0] trig_pos;
    logic [1:0]    state;

    always #5 clk = ~clk;

    capture_buffer #(.size(SZ), .saddr_w(SA)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .triggered(triggered), .done(done), .arm(arm),
        .read_start(read_start), .clear(clear),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .count(count), .trig_pos(trig_pos), .trig_seen(trig_seen), .state(state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [SZ-1:0] samples[$];
    int m_n, m_cnt, m_seen, m_pos;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Fill n beats; triggered rises once trig_at beats have been written.
    task automatic do_fill(input int n, input int trig_at, input int gap, input bit bod, input bit seq);
        int written;
        int guard;
        samples.delete();
        arm = 1'b1;
        triggered = (trig_at == 0);
        tick;
        arm = 1'b0;
        written = 0;
        guard = 0;
        while (written < n && guard < 2000) begin
            guard++;
            triggered = (written >= trig_at);
            s_tdata = seq ? SZ'(written) : $urandom;
            if (bod && written == n - 1) begin
                s_tvalid = 1'b1;
                done = 1'b1;
            end else begin
                s_tvalid = ($urandom_range(99) >= gap);
            end
            tick;
            if (s_tvalid) begin
                samples.push_back(s_tdata);
                written++;
            end
            if (done) break;
        end
        s_tvalid = 1'b0;
        if (!done) begin
            done = 1'b1;
            triggered = (written >= trig_at);
            tick;
        end
        done = 1'b0;
        triggered = 1'b0;
        m_n   = n;
        m_cnt = (n < DEPTH) ? n : DEPTH;
        m_seen = bod ? int'(trig_at <= n - 1) : int'(trig_at <= n);
        m_pos  = m_seen ? (((trig_at - (n - m_cnt)) % DEPTH) + DEPTH) % DEPTH : 0;
        chk("fill_written", written, n);
        chk("fill_state", state, 2);
        chk("fill_count", count, m_cnt);
        chk("fill_trig_seen", trig_seen, m_seen);
        chk("fill_trig_pos", trig_pos, m_pos);
    endtask

    // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random.
    task automatic do_read(input int mode, input int clear_at, input bit check_lat);
        logic [SZ-1:0] expq[$];
        logic [33:0]   prev;
        int total, k, first, sready_bad, bound;
        bit stalled, fin;
        for (int i = 0; i < m_cnt; i++) expq.push_back(samples[m_n - m_cnt + i]);
        if (TRL == 1) expq.push_back(SZ'((m_seen << (2*SA+1)) | (m_pos << (SA+1)) | m_cnt));
        total = m_cnt + TRL;
        read_start = 1'b1;
        tick;
        read_start = 1'b0;
        k = 0; first = -1; sready_bad = 0; stalled = 1'b0; prev = '0;
        bound = (total == 0) ? 10 : 300;
        for (int j = 1; j <= bound; j++) begin
            if (clear_at >= 0 && k == clear_at) begin
                clear = 1'b1;
                m_tready = 1'b0;
                tick;
                clear = 1'b0;
                chk("clear_vld", m_tvalid, 0);
                chk("clear_state", state, 0);
                return;
            end
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (j % 4 == 1) || (j % 4 == 0);
                default: m_tready = 1'($urandom_range(1));
            endcase
            if (m_tvalid && first < 0) first = j;
            if (s_tready) sready_bad++;
            if (stalled) chk("stable", {m_tvalid, m_tlast, m_tdata}, prev);
            stalled = m_tvalid && !m_tready;
            prev = {m_tvalid, m_tlast, m_tdata};
            fin = m_tvalid && m_tready && m_tlast;
            if (m_tvalid && m_tready) begin
                if (k < total) begin
                    chk("rd_data", m_tdata, expq[k]);
                    chk("rd_last", m_tlast, (k == total - 1));
                end else begin
                    chk("extra_beat", k, total);
                end
                k++;
            end
            tick;
            if (fin) break;
        end
        m_tready = 1'b0;
        chk("rd_beats", k, total);
        chk("rd_end_state", state, 2);
        chk("rd_tready_low", sready_bad, (total == 0) ? bound : 0);
        if (check_lat && total > 0) chk("rd_latency", first, 2);
    endtask

    initial begin
        reset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; triggered = 1'b0; done = 1'b0;
        arm = 1'b0; read_start = 1'b0; clear = 1'b0; m_tready = 1'b0;
        tick;
        tick;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_trig_seen", trig_seen, 0);
        chk("rst_trig_pos", trig_pos, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 1);
        reset = 1'b1;
        tick;

        // Basic, then beats offered in HOLD must be dropped and a re-read must match.
        do_fill(10, 3, 0, 1'b0, 1'b1);
        do_read(0, -1, 1'b1);
        s_tvalid = 1'b1;
        repeat (3) tick;
        s_tvalid = 1'b0;
        chk("hold_discard_count", count, 10);
        do_read(0, -1, 1'b1);

        do_fill(20, 17, 0, 1'b0, 1'b1);
        do_read(0, -1, 1'b1);

        do_fill(10, 3, 0, 1'b0, 1'b1);
        do_read(1, -1, 1'b0);

        do_fill(10, 100, 30, 1'b0, 1'b1);
        do_read(2, -1, 1'b0);

        do_fill(0, 100, 0, 1'b0, 1'b0);
        do_read(0, -1, 1'b0);

        do_fill(10, 3, 0, 1'b0, 1'b1);
        do_read(0, 4, 1'b0);

        // Synchronous reset in the middle of a fill.
        arm = 1'b1;
        tick;
        arm = 1'b0;
        s_tvalid = 1'b1;
        triggered = 1'b1;
        repeat (5) tick;
        s_tvalid = 1'b0;
        triggered = 1'b0;
        reset = 1'b0;
        tick;
        chk("midrst_state", state, 0);
        chk("midrst_count", count, 0);
        chk("midrst_trig_seen", trig_seen, 0);
        chk("midrst_trig_pos", trig_pos, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_s_tready", s_tready, 1);
        reset = 1'b1;
        tick;

        for (int t = 0; t < 10; t++) begin
            int n, ta, gap;
            bit bod;
            n   = $urandom_range(0, 40);
            ta  = $urandom_range(0, n + 3);
            gap = $urandom_range(0, 60);
            bod = (n > 0) && ($urandom_range(1) == 1);
            do_fill(n, ta, gap, bod, 1'b0);
            do_read($urandom_range(0, 2), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
